vec_packer: RTL and testbench

VEC_PACKER -- requirements
Module: vec_packer

---
 rtl/vec_packer.sv | 103 ++++++++++
 tb/tb_vec_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_packer.sv
// Serial-to-parallel packer: collects FIXED-bit elements into an NELEM-wide vector.
// Optional macro VEC_PACKER_SCALE_EN stores each element arithmetically shifted right by 8.

module vec_packer_slot #(
    parameter int FIXED = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_clr,
    input  logic [FIXED-1:0] i_d,
    output logic [FIXED-1:0] o_q
);
    logic [FIXED-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_q <= '0;
        else if (i_wr)  r_q <= i_d;
        else if (i_clr) r_q <= '0;
    end

    assign o_q = r_q;
endmodule

module vec_packer #(
    parameter int FIXED = 32,
    parameter int NELEM = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FIXED-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [NELEM*FIXED-1:0]     out_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NELEM+1)-1:0] out_count
);
    localparam int CW = $clog2(NELEM+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_wr_idx, r_count, w_wr_nxt;
    logic            w_in_ready, w_accept, w_last, w_flush, w_hshk;
    logic [FIXED-1:0] w_din;

`ifdef VEC_PACKER_SCALE_EN
    assign w_din = $signed(in_data) >>> 8;
`else
    assign w_din = in_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    // A flush only counts if the vector holds at least one element after this cycle's store.
    always_comb begin
        w_in_ready  = (r_state == FILL);
        w_accept    = in_valid & w_in_ready;
        w_last      = w_accept && (r_wr_idx == CW'(NELEM-1));
        w_wr_nxt    = r_wr_idx + CW'(w_accept);
        w_flush     = flush && w_in_ready && (w_wr_nxt != '0);
        w_hshk      = (r_state == HOLD) && out_ready;
        w_state_nxt = r_state;
        case (r_state)
            FILL: if (w_last || w_flush) w_state_nxt = HOLD;
            HOLD: if (w_hshk)            w_state_nxt = FILL;
            default:                     w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_hshk)        r_wr_idx <= '0;
            else if (w_accept) r_wr_idx <= w_wr_nxt;
            if (w_last || w_flush) r_count <= w_wr_nxt;
        end
    end

    // Slots at or above the post-store index are zero-padded on a flush.
    for (genvar i = 0; i < NELEM; i++) begin : g_slot
        localparam logic [CW-1:0] IDX = CW'(i);
        vec_packer_slot #(.FIXED(FIXED)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .i_wr  (w_accept && (r_wr_idx == IDX)),
            .i_clr (w_flush && (w_wr_nxt <= IDX)),
            .i_d   (w_din),
            .o_q   (out_vec[i*FIXED +: FIXED])
        );
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == HOLD);
    assign out_count = r_count;
endmodule

// File: tb/tb_vec_packer.sv
// Directed self-checking bench for vec_packer (FIXED=32, NELEM=24).
module tb_vec_packer;
    localparam int FIXED = 32;
    localparam int NELEM = 24;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [FIXED-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [NELEM*FIXED-1:0] out_vec;
    logic                   out_valid;
    logic                   out_ready;
    logic [4:0]             out_count;

    int n_chk = 0;
    int n_err = 0;

    vec_packer #(.FIXED(FIXED), .NELEM(NELEM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return out_vec[i*FIXED +: FIXED];
    endfunction

    function automatic logic [31:0] scl(input logic [31:0] x);
`ifdef VEC_PACKER_SCALE_EN
        return $signed(x) >>> 8;
`else
        return x;
`endif
    endfunction

    task automatic fill_n(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_vec_zero", 32'(out_vec == '0), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full fill, out_ready held high
        for (int k = 1; k <= 24; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            tick();
            if (k == 23) chk("fill_no_early_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        chk("full_slot0", slot(0), scl(32'd1));
        chk("full_slot23", slot(23), scl(32'd24));
        chk("full_count", 32'(out_count), 32'd24);
        tick();
        chk("full_valid_pulse", 32'(out_valid), 32'd0);
        chk("full_in_ready_back", 32'(in_ready), 32'd1);
        chk("after_hs_vec_kept", slot(5), scl(32'd6));

        // Backpressure: hold for 10 cycles, junk on input must be refused
        out_ready = 1'b0;
        fill_n(24, 32'd101);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_slot10", slot(10), scl(32'd111));
            chk("bp_slot23", slot(23), scl(32'd124));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_handshake_valid", 32'(out_valid), 32'd0);
        chk("bp_handshake_in_ready", 32'(in_ready), 32'd1);
        chk("bp_vec_after_hs", slot(0), scl(32'd101));

        // Flush together with the 6th element
        out_ready = 1'b0;
        fill_n(5, 32'd201);
        in_valid = 1'b1; in_data = 32'd206; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd1);
        chk("fl_count", 32'(out_count), 32'd6);
        chk("fl_slot0", slot(0), scl(32'd201));
        chk("fl_slot5", slot(5), scl(32'd206));
        ok = 1'b1;
        for (int j = 6; j < NELEM; j++) ok &= (slot(j) == 32'd0);
        chk("fl_pad_zero", 32'(ok), 32'd1);

        // Flush in HOLD is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hold_flush_valid", 32'(out_valid), 32'd1);
        chk("hold_flush_count", 32'(out_count), 32'd6);
        chk("hold_flush_slot5", slot(5), scl(32'd206));
        out_ready = 1'b1;
        tick();
        chk("fl_handshake", 32'(out_valid), 32'd0);

        // Flush with empty vector is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("empty_flush_valid", 32'(out_valid), 32'd0);
        chk("empty_flush_in_ready", 32'(in_ready), 32'd1);

        // Flush with no element in the same cycle
        out_ready = 1'b0;
        fill_n(3, 32'd301);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl3_valid", 32'(out_valid), 32'd1);
        chk("fl3_count", 32'(out_count), 32'd3);
        chk("fl3_slot0", slot(0), scl(32'd301));
        chk("fl3_slot2", slot(2), scl(32'd303));
        chk("fl3_slot3", slot(3), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("fl3_handshake", 32'(out_valid), 32'd0);

        // Reset mid-fill
        fill_n(12, 32'd401);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_vec_zero", 32'(out_vec == '0), 32'd1);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        fill_n(23, 32'd501);
        chk("mid_rst_no_early_valid", 32'(out_valid), 32'd0);
        fill_n(1, 32'd524);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd1);
        chk("mid_rst_slot0", slot(0), scl(32'd501));
        chk("mid_rst_slot11", slot(11), scl(32'd512));
        chk("mid_rst_slot23", slot(23), scl(32'd524));
        chk("mid_rst_count_full", 32'(out_count), 32'd24);
        out_ready = 1'b1;
        tick();

        // Scaling boundary values (identity in the default build)
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0100;
        tick();
        in_data = 32'hFFFF_FF00; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("scale_pos", slot(0), scl(32'h0000_0100));
        chk("scale_neg", slot(1), scl(32'hFFFF_FF00));
        chk("scale_count", 32'(out_count), 32'd2);
`ifdef VEC_PACKER_SCALE_EN
        chk("scale_pos_abs", slot(0), 32'h0000_0001);
        chk("scale_neg_abs", slot(1), 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
